mem_arb2: RTL and testbench
===========================

# mem_arb2

Two-requester arbiter and sequencer for the single-read-port / single-write-port synchronous memory (`mem_mod`). It sits between two client blocks and one memory instance. Each client issues read or write requests through a valid/ready handshake. The arbiter arbitrates the read port and the write port independently with round-robin fairness, drives the memory enables, addresses and write data, and routes each 1-cycle-latency read result back to the requester that issued it.

## Interface
- DATA_WIDTH, 8, data width of memory words and client data.
- MAX_ADDR, 16, memory depth in words.
- ADDRSIZE, $clog2(MAX_ADDR), address width.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- rK_valid  in  1  (K = 0, 1) requester K presents a request.
- rK_ready  out  1  request accepted this cycle; the transfer occurs when rK_valid && rK_ready.
- rK_we  in  1  1 = write, 0 = read.
- rK_addr  in  ADDRSIZE  request address.
- rK_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rK_rvalid  out  1  read data for requester K is valid this cycle.
- rK_rdata  out  DATA_WIDTH  read data, equal to mem_rd_data; meaningful only with rK_rvalid.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDRSIZE  memory read address.
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  ADDRSIZE  memory write address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_rd_data  in  DATA_WIDTH  memory read data, registered inside the memory, valid 1 cycle after mem_rd_en.

## Operation
- Read contenders are requesters with rK_valid && !rK_we. Write contenders are requesters with rK_valid && rK_we.
- Read and write arbitration are independent. A read from one requester and a write from the other are both granted in the same cycle.
- Each port has a 1-bit priority register (rd_prio, wr_prio) naming the favoured requester.
  - One contender on a port: that contender is granted.
  - Two contenders on a port: the requester named by the priority bit is granted.
  - After any grant to requester K on a port, that port's priority becomes 1-K. With no grant, priority holds.
- A requester presents one request at a time, so at most one port is granted per requester per cycle.
- rK_ready = grant to K on either port. It is combinational from valid, we and priority, and does not depend on ready.
- Read grant to K:
  - mem_rd_en=1 and mem_rd_addr=rK_addr.
  - Registers rd_pend<=1 and rd_owner<=K.
  - With no read grant, rd_pend<=0.
- Write grant to K: mem_wr_en=1, mem_wr_addr=rK_addr, mem_wr_data=rK_wdata.
- Ungranted cycles:
  - mem_rd_en=0 and mem_wr_en=0.
  - mem_rd_addr, mem_wr_addr and mem_wr_data are driven 0.
- Response routing: rK_rvalid = rd_pend && (rd_owner==K). Both rK_rdata outputs carry mem_rd_data.
- There is no response backpressure. Clients must accept rvalid when it asserts.
- Read and write to the same address in the same cycle: the read returns the old word. The new word is visible to reads granted on the following cycle or later.
- Reset (rst_n low at a posedge):
  - rd_prio=0, wr_prio=0, rd_pend=0, rd_owner=0.
  - While rst_n is low, all rK_ready, mem_rd_en and mem_wr_en are forced 0.
  - A read issued in the cycle before reset produces no rvalid.

## Timing
- Reset values: r0_ready=r1_ready=0, r0_rvalid=r1_rvalid=0, mem_rd_en=mem_wr_en=0, addresses and data 0.
- Acceptance has 0-cycle latency: ready is in the same cycle as valid when granted.
- Read latency: a read accepted in cycle T produces rK_rvalid in cycle T+1 with the data at the address as of before the posedge ending T.
- Throughput: 1 read plus 1 write per cycle. Back-to-back reads give rvalid on consecutive cycles.
- Fairness: with both requesters continuously contending on a port, grants alternate. The worst-case wait is 1 cycle.
- Priority registers update only on posedges with rst_n high.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with both valids high → all ready, enable and rvalid outputs are 0. The first cycle after release with both reading grants r0.
- Write then read: r0 writes 0xA5 to addr 3 in cycle T. r1 reads addr 3 in cycle T+1 → r1_rvalid=1 in T+2 with r1_rdata=0xA5, and r0_rvalid stays 0.
- Read contention: both requesters read continuously for 6 cycles → grants alternate r0,r1,r0,r1,r0,r1. Each rvalid follows its grant by 1 cycle to the correct owner.
- Mixed ports: r0 reads addr 5 (holding 0x11) while r1 writes 0x22 to addr 5 in the same cycle → both ready=1, r0_rdata=0x11. A following r0 read of addr 5 returns 0x22.
- Write contention: both write addr 0 (r0 data 0x01, r1 data 0x02) for 2 cycles from reset → r0 is granted first, r1 second. A subsequent read of addr 0 returns 0x02.
- Reset mid-read: r1 read granted in cycle T, rst_n=0 sampled at the end of T → r1_rvalid=0 in T+1, and priorities return to 0.

Source files
------------

// File: rtl/mem_arb2.sv
// Two-requester round-robin arbiter for a 1R/1W synchronous memory.
// Read and write ports arbitrate independently; read data is routed back to its issuer one cycle later.
module mem_arb2 #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 16,
  parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDRSIZE-1:0]   r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,

  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDRSIZE-1:0]   r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  output logic                  mem_rd_en,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  logic       rd_prio_q, rd_prio_d;
  logic       wr_prio_q, wr_prio_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic [1:0] rd_req, wr_req;
  logic [1:0] rd_gnt, wr_gnt;

  always_comb begin
    // Requests are masked while reset is asserted so no grant can leak out.
    rd_req = {r1_valid & ~r1_we, r0_valid & ~r0_we} & {2{rst_n}};
    wr_req = {r1_valid &  r1_we, r0_valid &  r0_we} & {2{rst_n}};

    rd_gnt[0] = rd_req[0] & (~rd_req[1] | ~rd_prio_q);
    rd_gnt[1] = rd_req[1] & (~rd_req[0] |  rd_prio_q);
    wr_gnt[0] = wr_req[0] & (~wr_req[1] | ~wr_prio_q);
    wr_gnt[1] = wr_req[1] & (~wr_req[0] |  wr_prio_q);

    r0_ready = rd_gnt[0] | wr_gnt[0];
    r1_ready = rd_gnt[1] | wr_gnt[1];

    mem_rd_en   = |rd_gnt;
    mem_rd_addr = '0;
    if (rd_gnt[0])      mem_rd_addr = r0_addr;
    else if (rd_gnt[1]) mem_rd_addr = r1_addr;

    mem_wr_en   = |wr_gnt;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (wr_gnt[0]) begin
      mem_wr_addr = r0_addr;
      mem_wr_data = r0_wdata;
    end else if (wr_gnt[1]) begin
      mem_wr_addr = r1_addr;
      mem_wr_data = r1_wdata;
    end

    rd_prio_d = rd_prio_q;
    if (rd_gnt[0])      rd_prio_d = 1'b1;
    else if (rd_gnt[1]) rd_prio_d = 1'b0;

    wr_prio_d = wr_prio_q;
    if (wr_gnt[0])      wr_prio_d = 1'b1;
    else if (wr_gnt[1]) wr_prio_d = 1'b0;

    rd_pend_d  = |rd_gnt;
    rd_owner_d = rd_owner_q;
    if (rd_gnt[0])      rd_owner_d = 1'b0;
    else if (rd_gnt[1]) rd_owner_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_prio_q  <= 1'b0;
      wr_prio_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_prio_q  <= rd_prio_d;
      wr_prio_q  <= wr_prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign r0_rvalid = rd_pend_q & ~rd_owner_q;
  assign r1_rvalid = rd_pend_q &  rd_owner_q;
  assign r0_rdata  = mem_rd_data;
  assign r1_rdata  = mem_rd_data;

endmodule

// File: tb/tb_mem_arb2.sv
// Randomized bench for mem_arb2 with a behavioural memory and a rule-level arbitration model.
module tb_mem_arb2;
  localparam int DW = 8;
  localparam int MA = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  mem_arb2 #(.DATA_WIDTH(DW), .MAX_ADDR(MA)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Memory instance the arbiter talks to: registered read, old data on same-address collision.
  logic [DW-1:0] mem [MA];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Reference model state
  int            rd_fav, wr_fav;
  int            pend_owner;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] shadow [MA];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input bit c0, input bit c1, input int fav);
    if (c0 && c1) return fav;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic drive(input int k, input bit v, input bit w, input int a, input int d);
    if (k == 0) begin
      r0_valid = v; r0_we = w; r0_addr = AW'(a); r0_wdata = DW'(d);
    end else begin
      r1_valid = v; r1_we = w; r1_addr = AW'(a); r1_wdata = DW'(d);
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  // Called mid-cycle: checks every output against the model, optionally drops reset
  // just before the closing edge, then advances the model across that edge.
  task automatic finish_cycle(input bit late_rst);
    int gr, gw, ra, wa;
    logic [DW-1:0] wd, nd;
    gr = pick(r0_valid && !r0_we && rst_n, r1_valid && !r1_we && rst_n, rd_fav);
    gw = pick(r0_valid &&  r0_we && rst_n, r1_valid &&  r1_we && rst_n, wr_fav);
    ra = (gr == 0) ? int'(r0_addr) : (gr == 1) ? int'(r1_addr) : 0;
    wa = (gw == 0) ? int'(r0_addr) : (gw == 1) ? int'(r1_addr) : 0;
    wd = (gw == 0) ? r0_wdata : (gw == 1) ? r1_wdata : '0;
    nd = shadow[ra];

    check_eq("r0_ready",    32'(r0_ready),    32'(gr == 0 || gw == 0));
    check_eq("r1_ready",    32'(r1_ready),    32'(gr == 1 || gw == 1));
    check_eq("mem_rd_en",   32'(mem_rd_en),   32'(gr >= 0));
    check_eq("mem_rd_addr", 32'(mem_rd_addr), 32'(ra));
    check_eq("mem_wr_en",   32'(mem_wr_en),   32'(gw >= 0));
    check_eq("mem_wr_addr", 32'(mem_wr_addr), 32'(wa));
    check_eq("mem_wr_data", 32'(mem_wr_data), 32'(wd));
    check_eq("r0_rvalid",   32'(r0_rvalid),   32'(pend_owner == 0));
    check_eq("r1_rvalid",   32'(r1_rvalid),   32'(pend_owner == 1));
    if (pend_owner == 0) check_eq("r0_rdata", 32'(r0_rdata), 32'(pend_data));
    if (pend_owner == 1) check_eq("r1_rdata", 32'(r1_rdata), 32'(pend_data));

    if (late_rst) begin
      #2 rst_n = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      rd_fav = 0; wr_fav = 0; pend_owner = -1;
    end else begin
      pend_owner = gr;
      if (gr >= 0) begin
        pend_data = nd;
        rd_fav = 1 - gr;
      end
      if (gw >= 0) begin
        shadow[wa] = wd;
        wr_fav = 1 - gw;
      end
    end
    #1;
  endtask

  initial begin
    rd_fav = 0; wr_fav = 0; pend_owner = -1; pend_data = '0;
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    repeat (2) begin #4; finish_cycle(1'b0); end
    rst_n = 1'b1;

    // Populate every word through the arbiter so the model knows all contents.
    for (int a = 0; a < MA; a++) begin
      drive(0, 1, 1, a, $urandom_range(255));
      #4; finish_cycle(1'b0);
    end

    // Reset held with both requesters reading
    rst_n = 1'b0;
    drive(0, 1, 0, 1, 0); drive(1, 1, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check_eq("rst_r0_ready", 32'(r0_ready), 32'(0));
      check_eq("rst_r1_ready", 32'(r1_ready), 32'(0));
      finish_cycle(1'b0);
    end
    rst_n = 1'b1;
    #4;
    check_eq("post_rst_r0_gnt", 32'(r0_ready), 32'(1));
    check_eq("post_rst_r1_gnt", 32'(r1_ready), 32'(0));
    finish_cycle(1'b0);

    // Write then read on the other requester
    idle(); drive(0, 1, 1, 3, 8'hA5);
    #4; finish_cycle(1'b0);
    idle(); drive(1, 1, 0, 3, 0);
    #4; finish_cycle(1'b0);
    idle();
    #4;
    check_eq("wr_rd_r1_rvalid", 32'(r1_rvalid), 32'(1));
    check_eq("wr_rd_r1_rdata",  32'(r1_rdata),  32'(8'hA5));
    check_eq("wr_rd_r0_rvalid", 32'(r0_rvalid), 32'(0));
    finish_cycle(1'b0);

    // Read contention from a fresh reset: grants alternate starting at r0
    rst_n = 1'b0; idle();
    #4; finish_cycle(1'b0);
    rst_n = 1'b1;
    drive(0, 1, 0, 4, 0); drive(1, 1, 0, 7, 0);
    for (int i = 0; i < 6; i++) begin
      #4;
      check_eq("rd_alt_r0", 32'(r0_ready), 32'(i % 2 == 0));
      check_eq("rd_alt_r1", 32'(r1_ready), 32'(i % 2 == 1));
      if (i > 0) check_eq("rd_alt_rv1", 32'(r1_rvalid), 32'(i % 2 == 0));
      finish_cycle(1'b0);
    end

    // Mixed ports on the same address: read sees the old word
    idle(); drive(0, 1, 1, 5, 8'h11);
    #4; finish_cycle(1'b0);
    drive(0, 1, 0, 5, 0); drive(1, 1, 1, 5, 8'h22);
    #4;
    check_eq("mix_r0_ready", 32'(r0_ready), 32'(1));
    check_eq("mix_r1_ready", 32'(r1_ready), 32'(1));
    finish_cycle(1'b0);
    idle(); drive(0, 1, 0, 5, 0);
    #4;
    check_eq("mix_old_data", 32'(r0_rdata), 32'(8'h11));
    finish_cycle(1'b0);
    idle();
    #4;
    check_eq("mix_new_data", 32'(r0_rdata), 32'(8'h22));
    finish_cycle(1'b0);

    // Write contention from reset
    rst_n = 1'b0; idle();
    #4; finish_cycle(1'b0);
    rst_n = 1'b1;
    drive(0, 1, 1, 0, 8'h01); drive(1, 1, 1, 0, 8'h02);
    #4;
    check_eq("wc_first_r0", 32'(r0_ready), 32'(1));
    finish_cycle(1'b0);
    #4;
    check_eq("wc_second_r1", 32'(r1_ready), 32'(1));
    finish_cycle(1'b0);
    idle(); drive(0, 1, 0, 0, 0);
    #4; finish_cycle(1'b0);
    idle();
    #4;
    check_eq("wc_final_data", 32'(r0_rdata), 32'(8'h02));
    finish_cycle(1'b0);

    // Reset lands on the edge ending a granted read (plus a write that moves wr priority)
    idle(); drive(1, 1, 0, 9, 0); drive(0, 1, 1, 10, 8'h5A);
    #4;
    check_eq("mr_r1_ready", 32'(r1_ready), 32'(1));
    finish_cycle(1'b1);
    rst_n = 1'b1;
    drive(0, 1, 1, 11, 8'h33); drive(1, 1, 1, 12, 8'h44);
    #4;
    check_eq("mr_no_rvalid", 32'(r1_rvalid), 32'(0));
    check_eq("mr_wprio_r0",  32'(r0_ready),  32'(1));
    finish_cycle(1'b0);

    // Randomized traffic, with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(49) != 0);
      drive(0, $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(MA - 1), $urandom_range(255));
      drive(1, $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(MA - 1), $urandom_range(255));
      #4; finish_cycle($urandom_range(39) == 0);
    end
    rst_n = 1'b1;
    idle();
    #4; finish_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
